// File: rtl/axil_mem_slave.sv
// AXI4-Lite slave memory: one-entry AW and W holding slots feed a single commit stage,
// reads return one edge after the AR handshake. Words beyond DEPTH answer SLVERR.
module axil_mem_slave #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DEPTH    = 256,
   parameter logic [31:0] INIT_VAL = 32'h12345678
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_W-1:0]     s_axi_awaddr,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [DATA_W-1:0]     s_axi_wdata,
   input  logic [DATA_W/8-1:0]   s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [ADDR_W-1:0]     s_axi_araddr,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [DATA_W-1:0]     s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready
);

   localparam int unsigned STRB_W  = DATA_W / 8;
   localparam int unsigned LSB     = $clog2(STRB_W);
   localparam int unsigned IDX_W   = ADDR_W - LSB;
   localparam int unsigned MEM_AW  = $clog2(DEPTH);
   localparam logic [DATA_W-1:0] INIT_WORD = {(DATA_W / 32){INIT_VAL}};
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic [DATA_W-1:0] merge_lanes(
      input logic [DATA_W-1:0] old_word,
      input logic [DATA_W-1:0] new_word,
      input logic [STRB_W-1:0] strb
   );
      logic [DATA_W-1:0] res;
      res = old_word;
      for (int i = 0; i < STRB_W; i++) begin
         if (strb[i]) begin
            res[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return res;
   endfunction

   function automatic logic in_range(input logic [IDX_W-1:0] idx);
      return (idx < IDX_W'(DEPTH));
   endfunction

   // Power-up content only; reset deliberately leaves the array alone.
   logic [DATA_W-1:0] mem_r [DEPTH] = '{default: INIT_WORD};

   logic              aw_full_r;
   logic              w_full_r;
   logic              awready_r;
   logic              wready_r;
   logic [IDX_W-1:0]  aw_idx_r;
   logic [DATA_W-1:0] w_data_r;
   logic [STRB_W-1:0] w_strb_r;
   logic              bvalid_r;
   logic [1:0]        bresp_r;
   logic              rvalid_r;
   logic [1:0]        rresp_r;
   logic [DATA_W-1:0] rdata_r;

   logic              aw_full_nxt_s;
   logic              w_full_nxt_s;
   logic              aw_hs_s;
   logic              w_hs_s;
   logic              commit_s;
   logic              commit_ok_s;
   logic              arready_s;
   logic              ar_hs_s;
   logic [IDX_W-1:0]  ar_idx_s;
   logic              unused_s;

   assign aw_hs_s     = s_axi_awvalid && awready_r;
   assign w_hs_s      = s_axi_wvalid && wready_r;
   assign commit_s    = aw_full_r && w_full_r && (!bvalid_r || s_axi_bready);
   assign commit_ok_s = commit_s && in_range(aw_idx_r);
   assign arready_s   = !rvalid_r || s_axi_rready;
   assign ar_hs_s     = s_axi_arvalid && arready_s;
   assign ar_idx_s    = s_axi_araddr[ADDR_W-1:LSB];
   assign unused_s    = ^{s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};

   // Next occupancy of the holding slots; a full slot cannot also be refilled on the commit edge.
   always_comb begin
      aw_full_nxt_s = aw_full_r;
      w_full_nxt_s  = w_full_r;
      if (commit_s) begin
         aw_full_nxt_s = 1'b0;
         w_full_nxt_s  = 1'b0;
      end else begin
         if (aw_hs_s) begin
            aw_full_nxt_s = 1'b1;
         end else begin
            aw_full_nxt_s = aw_full_r;
         end
         if (w_hs_s) begin
            w_full_nxt_s = 1'b1;
         end else begin
            w_full_nxt_s = w_full_r;
         end
      end
   end

   // Write channel state: holding slots, registered readies and the B response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_full_r <= 1'b0;
         w_full_r  <= 1'b0;
         awready_r <= 1'b1;
         wready_r  <= 1'b1;
         aw_idx_r  <= {IDX_W{1'b0}};
         w_data_r  <= {DATA_W{1'b0}};
         w_strb_r  <= {STRB_W{1'b0}};
         bvalid_r  <= 1'b0;
         bresp_r   <= RESP_OKAY;
      end else begin
         aw_full_r <= aw_full_nxt_s;
         w_full_r  <= w_full_nxt_s;
         awready_r <= !aw_full_nxt_s;
         wready_r  <= !w_full_nxt_s;
         if (aw_hs_s) begin
            aw_idx_r <= s_axi_awaddr[ADDR_W-1:LSB];
         end
         if (w_hs_s) begin
            w_data_r <= s_axi_wdata;
            w_strb_r <= s_axi_wstrb;
         end
         // A commit coinciding with bready replaces the response instead of dropping bvalid.
         if (commit_s) begin
            bvalid_r <= 1'b1;
            bresp_r  <= in_range(aw_idx_r) ? RESP_OKAY : RESP_SLVERR;
         end else if (s_axi_bready) begin
            bvalid_r <= 1'b0;
         end
      end
   end

   // Single write port; nonblocking update lets a same-edge read see the old word.
   always_ff @(posedge clk) begin
      if (commit_ok_s) begin
         mem_r[aw_idx_r[MEM_AW-1:0]] <= merge_lanes(mem_r[aw_idx_r[MEM_AW-1:0]], w_data_r, w_strb_r);
      end
   end

   // Read channel: capture on AR handshake, hold while the master stalls R.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_r <= 1'b0;
         rresp_r  <= RESP_OKAY;
         rdata_r  <= {DATA_W{1'b0}};
      end else if (ar_hs_s) begin
         rvalid_r <= 1'b1;
         if (in_range(ar_idx_s)) begin
            rdata_r <= mem_r[ar_idx_s[MEM_AW-1:0]];
            rresp_r <= RESP_OKAY;
         end else begin
            rdata_r <= {DATA_W{1'b0}};
            rresp_r <= RESP_SLVERR;
         end
      end else if (s_axi_rready) begin
         rvalid_r <= 1'b0;
      end
   end

   assign s_axi_awready = awready_r;
   assign s_axi_wready  = wready_r;
   assign s_axi_bvalid  = bvalid_r;
   assign s_axi_bresp   = bresp_r;
   assign s_axi_arready = arready_s;
   assign s_axi_rvalid  = rvalid_r;
   assign s_axi_rresp   = rresp_r;
   assign s_axi_rdata   = rdata_r;

endmodule

// File: tb/tb_axil_mem_slave.sv
// Bench for axil_mem_slave: 32-bit instance driven from a vector table with B/R scoreboards,
// plus hand sequences for latency, ordering, back-pressure and a 64-bit instance.
module tb_axil_mem_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   logic        x_rst_n;
   logic [31:0] x_awaddr, x_araddr;
   logic [63:0] x_wdata, x_rdata;
   logic [7:0]  x_wstrb;
   logic        x_awvalid, x_awready, x_wvalid, x_wready, x_bvalid, x_bready;
   logic        x_arvalid, x_arready, x_rvalid, x_rready;
   logic [1:0]  x_bresp, x_rresp;

   int errors = 0;
   int checks = 0;

   typedef struct packed { logic [31:0] d; logic [1:0] r; } rexp_t;
   logic [1:0] bq[$];
   rexp_t      rq[$];

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;
   vec_t vecs[14];

   always #5 clk = ~clk;

   axil_mem_slave u_dut32 (
      .clk(clk), .rst_n(rst_n),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
   );

   axil_mem_slave #(.DATA_W(64)) u_dut64 (
      .clk(clk), .rst_n(x_rst_n),
      .s_axi_awaddr(x_awaddr), .s_axi_awvalid(x_awvalid), .s_axi_awready(x_awready),
      .s_axi_wdata(x_wdata), .s_axi_wstrb(x_wstrb), .s_axi_wvalid(x_wvalid), .s_axi_wready(x_wready),
      .s_axi_bresp(x_bresp), .s_axi_bvalid(x_bvalid), .s_axi_bready(x_bready),
      .s_axi_araddr(x_araddr), .s_axi_arvalid(x_arvalid), .s_axi_arready(x_arready),
      .s_axi_rdata(x_rdata), .s_axi_rresp(x_rresp), .s_axi_rvalid(x_rvalid), .s_axi_rready(x_rready)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Scoreboard: every B/R handshake on the 32-bit instance pops one expected response.
   always @(negedge clk) begin
      if (bvalid && bready) begin
         if (bq.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected: got bvalid=1 bresp=%b, required no response", bresp);
         end else begin
            chk("bresp", 64'(bresp), 64'(bq.pop_front()));
         end
      end
      if (rvalid && rready) begin
         if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_unexpected: got rvalid=1 rdata=%h, required no response", rdata);
         end else begin
            rexp_t e;
            e = rq.pop_front();
            chk("rdata", 64'(rdata), 64'(e.d));
            chk("rresp", 64'(rresp), 64'(e.r));
         end
      end
   end

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] eb);
      int  n;
      bit  aw_ok, w_ok, a_hs, w_hs;
      n = 0; aw_ok = 0; w_ok = 0;
      bq.push_back(eb);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      while (!(aw_ok && w_ok) && n < 100) begin
         @(negedge clk);
         a_hs = awvalid && awready;
         w_hs = wvalid && wready;
         @(posedge clk); #1;
         if (a_hs) begin aw_ok = 1; awvalid = 1'b0; end
         if (w_hs) begin w_ok = 1; wvalid = 1'b0; end
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      if (!(aw_ok && w_ok)) begin
         checks++; errors++;
         $display("FAIL aw_w_timeout: got aw=%0d w=%0d accepted, required both", aw_ok, w_ok);
      end
   endtask

   task automatic axi_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
      int n;
      bit hs;
      n = 0; hs = 0;
      rq.push_back(rexp_t'{d: ed, r: er});
      araddr = a; arvalid = 1'b1;
      while (!hs && n < 100) begin
         @(negedge clk);
         hs = arready;
         @(posedge clk); #1;
         n++;
      end
      arvalid = 1'b0;
      if (!hs) begin
         checks++; errors++;
         $display("FAIL ar_timeout: got arready=0 for %0d cycles, required a handshake", n);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((bq.size() != 0 || rq.size() != 0) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (bq.size() != 0 || rq.size() != 0) begin
         checks++; errors++;
         $display("FAIL resp_timeout: got %0d B and %0d R outstanding, required 0", bq.size(), rq.size());
         bq.delete();
         rq.delete();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b1, 32'h0000_0030, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0};
      vecs[1]  = '{1'b0, 32'h0000_0030, 32'h0,         4'h0, 2'b00, 32'h12BB_56DD};
      vecs[2]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 2'b00, 32'h1234_5678};
      vecs[3]  = '{1'b1, 32'h0000_0400, 32'h1111_1111, 4'hF, 2'b10, 32'h0};
      vecs[4]  = '{1'b0, 32'h0000_0400, 32'h0,         4'h0, 2'b10, 32'h0};
      vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'h1234_5678};
      vecs[6]  = '{1'b1, 32'h0000_03FC, 32'h0102_0304, 4'hF, 2'b00, 32'h0};
      vecs[7]  = '{1'b0, 32'h0000_03FE, 32'h0,         4'h0, 2'b00, 32'h0102_0304};
      vecs[8]  = '{1'b1, 32'h0000_0044, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0};
      vecs[9]  = '{1'b0, 32'h0000_0044, 32'h0,         4'h0, 2'b00, 32'h1234_5678};
      vecs[10] = '{1'b1, 32'h0000_0048, 32'h1122_3344, 4'hA, 2'b00, 32'h0};
      vecs[11] = '{1'b0, 32'h0000_0048, 32'h0,         4'h0, 2'b00, 32'h1134_3378};
      vecs[12] = '{1'b0, 32'hFFFF_FFF0, 32'h0,         4'h0, 2'b10, 32'h0};
      vecs[13] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};

      rst_n = 1'b0; x_rst_n = 1'b0;
      awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
      x_awaddr = '0; x_wdata = '0; x_wstrb = '0; x_araddr = '0;
      x_awvalid = 1'b0; x_wvalid = 1'b0; x_arvalid = 1'b0; x_bready = 1'b1; x_rready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_awready", 64'(awready), 64'd1);
      chk("rst_wready",  64'(wready),  64'd1);
      chk("rst_bvalid",  64'(bvalid),  64'd0);
      chk("rst_bresp",   64'(bresp),   64'd0);
      chk("rst_rvalid",  64'(rvalid),  64'd0);
      chk("rst_rresp",   64'(rresp),   64'd0);
      chk("rst_rdata",   64'(rdata),   64'd0);
      chk("rst_arready", 64'(arready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1; x_rst_n = 1'b1;

      // AW+W together: B two edges later, then R one edge after AR.
      bq.push_back(2'b00);
      awaddr = 32'h10; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      chk("aw_w_ready", 64'(awready && wready), 64'd1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      chk("b_lat_early", 64'(bvalid), 64'd0);
      @(negedge clk);
      chk("b_lat", 64'(bvalid), 64'd1);
      wait_idle();
      rq.push_back(rexp_t'{d: 32'hDEAD_BEEF, r: 2'b00});
      araddr = 32'h10; arvalid = 1'b1;
      @(negedge clk);
      chk("r_lat_early", 64'(rvalid), 64'd0);
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      chk("r_lat", 64'(rvalid), 64'd1);
      wait_idle();

      for (int i = 0; i < 14; i++) begin
         if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
         else            axi_read(vecs[i].addr, vecs[i].rdata, vecs[i].resp);
         wait_idle();
      end

      // W three cycles ahead of AW.
      bq.push_back(2'b00);
      wdata = 32'hCAFE_0001; wstrb = 4'hF; wvalid = 1'b1;
      @(posedge clk); #1;
      wvalid = 1'b0;
      @(negedge clk);
      chk("w_slot_held", 64'(wready), 64'd0);
      chk("aw_slot_free", 64'(awready), 64'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      awaddr = 32'h20; awvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0;
      wait_idle();
      axi_read(32'h20, 32'hCAFE_0001, 2'b00);
      wait_idle();

      // AW three cycles ahead of W.
      bq.push_back(2'b00);
      awaddr = 32'h20; awvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0;
      @(negedge clk);
      chk("aw_slot_held", 64'(awready), 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      wdata = 32'hCAFE_0002; wstrb = 4'hF; wvalid = 1'b1;
      @(posedge clk); #1;
      wvalid = 1'b0;
      wait_idle();
      axi_read(32'h20, 32'hCAFE_0002, 2'b00);
      wait_idle();

      // B stalled: first response held, second write parks in the slots.
      bready = 1'b0;
      bq.push_back(2'b00);
      bq.push_back(2'b00);
      awaddr = 32'h50; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1;
      awaddr = 32'h54; wdata = 32'h5A5A_5A5A;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i > 0) chk("b_held", 64'(bvalid), 64'd1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("b_held_resp", 64'(bresp), 64'd0);
      chk("bp_awready", 64'(awready), 64'd0);
      chk("bp_wready", 64'(wready), 64'd0);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1;
      wait_idle();
      axi_read(32'h50, 32'hA5A5_A5A5, 2'b00);
      axi_read(32'h54, 32'h5A5A_5A5A, 2'b00);
      wait_idle();

      // R stalled: data held, arready low, next AR accepted with rready.
      rready = 1'b0;
      rq.push_back(rexp_t'{d: 32'hA5A5_A5A5, r: 2'b00});
      araddr = 32'h50; arvalid = 1'b1;
      @(posedge clk); #1;
      araddr = 32'h54;
      rq.push_back(rexp_t'{d: 32'h5A5A_5A5A, r: 2'b00});
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("r_held_valid", 64'(rvalid), 64'd1);
         chk("r_held_data", 64'(rdata), 64'hA5A5_A5A5);
         chk("rp_arready", 64'(arready), 64'd0);
         @(posedge clk); #1;
      end
      rready = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0;
      wait_idle();

      // 64-bit instance: upper-half strobe, then reset during a pending commit.
      x_awaddr = 32'h8; x_wdata = 64'hFFEE_DDCC_BBAA_9988; x_wstrb = 8'hF0;
      x_awvalid = 1'b1; x_wvalid = 1'b1;
      @(negedge clk);
      chk("x_aw_w_ready", 64'(x_awready && x_wready), 64'd1);
      @(posedge clk); #1;
      x_awvalid = 1'b0; x_wvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("x_bvalid", 64'(x_bvalid), 64'd1);
      chk("x_bresp", 64'(x_bresp), 64'd0);
      @(posedge clk); #1;
      x_araddr = 32'h8; x_arvalid = 1'b1;
      @(posedge clk); #1;
      x_arvalid = 1'b0;
      @(negedge clk);
      chk("x_rvalid", 64'(x_rvalid), 64'd1);
      chk("x_rdata_upper", x_rdata, 64'hFFEE_DDCC_1234_5678);
      @(posedge clk); #1;

      x_awaddr = 32'h10; x_wdata = 64'h0; x_wstrb = 8'hFF; x_awvalid = 1'b1; x_wvalid = 1'b1;
      @(posedge clk); #1;
      x_awvalid = 1'b0; x_wvalid = 1'b0;
      x_rst_n = 1'b0;
      @(negedge clk);
      chk("xr_awready", 64'(x_awready), 64'd1);
      chk("xr_wready",  64'(x_wready),  64'd1);
      chk("xr_bvalid",  64'(x_bvalid),  64'd0);
      chk("xr_bresp",   64'(x_bresp),   64'd0);
      chk("xr_rvalid",  64'(x_rvalid),  64'd0);
      chk("xr_rresp",   64'(x_rresp),   64'd0);
      chk("xr_rdata",   x_rdata,        64'd0);
      chk("xr_arready", 64'(x_arready), 64'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      x_rst_n = 1'b1;
      @(negedge clk);
      chk("x_no_b_after_rst", 64'(x_bvalid), 64'd0);
      @(posedge clk); #1;
      x_araddr = 32'h10; x_arvalid = 1'b1;
      @(posedge clk); #1;
      x_arvalid = 1'b0;
      @(negedge clk);
      chk("x_rst_rvalid", 64'(x_rvalid), 64'd1);
      chk("x_rst_no_write", x_rdata, 64'h1234_5678_1234_5678);
      @(posedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axil_mem_slave.md
# axil_mem_slave

Parametrised AXI4-Lite slave memory: the next generation of our minimal AXI-Lite test target behind the PCIe AXI-MM bridge. Adds configurable data width and depth, byte-strobe writes, independent AW/W acceptance, SLVERR on out-of-range addresses and fully specified back-pressure on B and R. It serves as a scratch/register target for host-side DMA and MMIO bring-up.

## Interface
- DATA_W, 32, data width; 32 or 64 only
- ADDR_W, 32, AXI address width
- DEPTH, 256, number of DATA_W words; power of two, 2..4096
- INIT_VAL, 32'h12345678 replicated to DATA_W, power-up content of every word (not re-applied by reset)
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- s_axi_awaddr  in  ADDR_W  write address
- s_axi_awvalid  in  1 / s_axi_awready  out  1
- s_axi_wdata  in  DATA_W / s_axi_wstrb  in  DATA_W/8 / s_axi_wvalid  in  1 / s_axi_wready  out  1
- s_axi_bresp  out  2 / s_axi_bvalid  out  1 / s_axi_bready  in  1
- s_axi_araddr  in  ADDR_W / s_axi_arvalid  in  1 / s_axi_arready  out  1
- s_axi_rdata  out  DATA_W / s_axi_rresp  out  2 / s_axi_rvalid  out  1 / s_axi_rready  in  1

## Operation
- LSB = log2(DATA_W/8); word index = addr[ADDR_W-1:LSB]; addr[LSB-1:0] ignored. Index >= DEPTH is out of range.
- Write path: one-entry AW holding register (aw_full) and one-entry W holding register (w_full).
  - awready = !aw_full; wready = !w_full. Both are driven directly from flops.
  - AW and W may arrive in either order or in the same cycle. Each is captured on its own handshake.
  - Commit fires at an edge where aw_full && w_full && (!bvalid || bready). On commit:
    - In range: each byte lane i with wstrb[i]=1 is written; lanes with wstrb[i]=0 keep their old value. bresp=OKAY (00).
    - Out of range: memory is unchanged. bresp=SLVERR (10).
    - bvalid<=1, aw_full<=0, w_full<=0.
  - bvalid clears on an edge with bready && !commit. If bready and a new commit coincide, bvalid stays 1 with the new bresp.
- Read path: arready = !rvalid || rready, combinational from the rvalid flop and rready.
  - On AR handshake: rdata<=mem[idx], rresp=OKAY; rvalid<=1.
  - Out-of-range read: rdata<=0, rresp=SLVERR.
  - rdata and rresp are held stable while rvalid && !rready.
  - rvalid clears on rready with no new AR handshake in the same cycle.
- Same-edge read and write commit to the same word: the read returns the pre-write data.
- The memory is distributed RAM with one write port and one read port.

## Timing
- Reset (async assert, sync release): awready=1, wready=1, bvalid=0, bresp=00, rvalid=0, rresp=00, rdata=0, arready=1, aw_full=0, w_full=0. Memory contents are untouched.
- Reset mid-transaction aborts it. Held AW/W entries are dropped, and a pending B or R is discarded without a write.
- Write latency: the later of the AW/W handshakes at edge N gives commit at edge N+1, with bvalid high after N+1. Peak throughput is one write per 2 cycles.
- Read latency: AR handshake at edge N gives rvalid high after N. With rready held at 1, reads run back-to-back at 1 per cycle.
- A stalled B stalls commits only. AW and W can each still fill their single holding slot, then deassert ready.
- Protocol: valid signals never depend combinationally on ready. bvalid and rvalid never drop before their handshake.

## Test plan
- Reset then AW+W in the same cycle: addr 0x10, data 0xDEADBEEF, strb 0xF -> bvalid 2 cycles later with OKAY. Then read 0x10 -> rdata 0xDEADBEEF, OKAY, rvalid 1 cycle after the AR handshake.
- W 3 cycles before AW, then AW 3 cycles before W, addr 0x20 -> both orders give one B each and the correct data. A fresh word reads 0x12345678.
- Strobe: write 0xAABBCCDD to 0x30 with strb 0x5, over initial 0x12345678 -> read 0x12BB56DD.
- Out of range: DEPTH=256, DATA_W=32, write/read 0x400 -> bresp 10, rresp 10, rdata 0. Word 0 is unchanged.
- Back-pressure: bready=0 for 10 cycles with 2 writes offered -> first B held stable, second AW/W captured, then awready/wready=0. Same for rready=0: rdata stable and arready=0.
- DATA_W=64: strb 0xF0 writes the upper half only. Assert rst_n low mid-write -> all outputs take reset values and no memory update occurs.
